// File: rtl/addn_seq_pkg.sv
// addn_seq_pkg: shared state type and sizing helpers for the chunked sequential adder
package addn_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/addn_chunk.sv
// addn_chunk: combinational CHUNK-bit ripple adder exposing the carry into its MSB
module addn_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/addn_seq.sv
// addn_seq: WIDTH-bit adder summing CHUNK bits per cycle behind valid/ready handshakes; OV port added when ADDN_SEQ_OVF_EN is defined
module addn_seq
  import addn_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
`ifdef ADDN_SEQ_OVF_EN
  output logic             OV,
`endif
  output logic             CO
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW = idx_w(NCHUNK);
  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("addn_seq: WIDTH must be >= 1 and a multiple of CHUNK");
  end
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r, acc, acc_nxt;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] s_c;
  logic carry, c_o, c_m, last;
  assign last = idx == IW'(NCHUNK - 1);
  addn_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a       (a_r[int'(idx)*CHUNK +: CHUNK]),
    .b       (b_r[int'(idx)*CHUNK +: CHUNK]),
    .ci      (carry),
    .s       (s_c),
    .co      (c_o),
    .c_msb_in(c_m)
  );
  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(idx)*CHUNK +: CHUNK] = s_c;
  end
  always_comb begin
    nxt = (state == IDLE && IN_VALID) ? RUN :
          (state == RUN && last)      ? DONE :
          (state == DONE && OUT_READY) ? IDLE : state;
  end
  assign IN_READY  = (state == IDLE) && !RST;
  assign OUT_VALID = state == DONE;
  always_ff @(posedge CLK) state <= RST ? IDLE : nxt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      S     <= '0;
      CO    <= 1'b0;
    end else if (state == IDLE && IN_VALID) begin
      a_r   <= A;
      b_r   <= B;
      carry <= CI;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      carry <= c_o;
      idx   <= idx + 1'b1;
      if (last) begin
        S  <= acc_nxt;
        CO <= c_o;
      end
    end
  end
`ifdef ADDN_SEQ_OVF_EN
  always_ff @(posedge CLK) begin
    if (RST) OV <= 1'b0;
    else if (state == RUN && last) OV <= c_m ^ c_o;
  end
`else
  logic unused_c_msb;
  assign unused_c_msb = c_m;
`endif
endmodule
